// File: rtl/idma_chan_scheduler.sv
// idma_chan_scheduler
// Shares one iDMA backend between NumChan register frontends. A round-robin
// arbiter picks one eligible frontend, holds its request stable toward the
// backend until accepted, and records the issuing channel in an in-order ID
// queue so each backend completion pulse is routed back to its owner.

module idma_chan_scheduler #(
    parameter int NumChan     = 4,
    parameter int ReqWidth    = 192,
    parameter int MaxInFlight = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumChan*ReqWidth-1:0] chan_req_i,
    input  logic [NumChan-1:0]          chan_valid_i,
    output logic [NumChan-1:0]          chan_ready_o,
    input  logic [NumChan-1:0]          chan_enable_i,
    output logic [ReqWidth-1:0]         be_req_o,
    output logic                        be_valid_o,
    input  logic                        be_ready_i,
    input  logic                        be_complete_i,
    output logic [NumChan-1:0]          chan_done_o,
    output logic [NumChan-1:0]          chan_busy_o,
    output logic [NumChan-1:0]          irq_o,
    input  logic [NumChan-1:0]          irq_clr_i,
    output logic                        idle_o,
    output logic                        err_o
);

    localparam int ChanIdW = $clog2(NumChan);
    localparam int CntW    = $clog2(MaxInFlight + 1);
    localparam int PtrW    = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;

    localparam logic [CntW-1:0]    MaxOcc   = CntW'(MaxInFlight);
    localparam logic [ChanIdW-1:0] LastChan = ChanIdW'(NumChan - 1);
    localparam logic [PtrW-1:0]    LastSlot = PtrW'(MaxInFlight - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Channel after c, wrapping at NumChan (works for non-power-of-2 counts).
    function automatic logic [ChanIdW-1:0] next_chan(input logic [ChanIdW-1:0] c);
        return (c == LastChan) ? '0 : c + ChanIdW'(1);
    endfunction

    // Queue slot after p, wrapping at MaxInFlight.
    function automatic logic [PtrW-1:0] next_slot(input logic [PtrW-1:0] p);
        return (p == LastSlot) ? '0 : p + PtrW'(1);
    endfunction

    // One-hot channel vector with bit c set.
    function automatic logic [NumChan-1:0] chan_onehot(input logic [ChanIdW-1:0] c);
        logic [NumChan-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Arbiter / offer state
    state_t               state_q, state_d;
    logic [ChanIdW-1:0]   rr_ptr_q;
    logic [ChanIdW-1:0]   held_chan_q;
    logic [ReqWidth-1:0]  held_req_q;

    // In-order ID queue of issued transfers
    logic [ChanIdW-1:0]   id_q [MaxInFlight];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      occ_q, occ_d;

    // Per-channel count of held + outstanding transfers
    logic [NumChan-1:0][CntW-1:0] cnt_q, cnt_d;

    logic [NumChan-1:0]   eligible;
    logic                 grant_found;
    logic [ChanIdW-1:0]   grant_idx;
    logic                 grant;
    logic                 push;
    logic                 pop;
    logic                 err_set;
    logic [ChanIdW-1:0]   head;
    logic [NumChan-1:0]   done_d;

    assign eligible = chan_valid_i & chan_enable_i;

    // Round-robin search: first eligible channel at or after rr_ptr_q.
    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NumChan; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NumChan) begin
                cand = cand - NumChan;
            end
            if (!grant_found && eligible[ChanIdW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ChanIdW'(cand);
            end
        end
    end

    // A grant needs an idle arbiter and room for one more in-flight transfer;
    // in IDLE the outstanding count is just the queue occupancy. Held in reset
    // so chan_ready_o reads 0 while rst_i is asserted.
    assign grant        = (state_q == IDLE) && grant_found && (occ_q < MaxOcc) && !rst_i;
    assign chan_ready_o = grant ? chan_onehot(grant_idx) : '0;

    assign push    = (state_q == OFFER) && be_ready_i;
    assign head    = id_q[rd_ptr_q];
    assign pop     = be_complete_i && (occ_q != '0);
    assign err_set = be_complete_i && (occ_q == '0);
    assign done_d  = pop ? chan_onehot(head) : '0;

    assign be_valid_o = (state_q == OFFER);
    assign be_req_o   = held_req_q;

    // Next-state logic: grant moves to OFFER, backend acceptance returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)      state_d = OFFER;
            OFFER:   if (be_ready_i) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // State register, captured request, and round-robin pointer advance on issue.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            held_chan_q <= '0;
            held_req_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                held_chan_q <= grant_idx;
                held_req_q  <= chan_req_i[grant_idx*ReqWidth +: ReqWidth];
            end
            if (push) begin
                rr_ptr_q <= next_chan(held_chan_q);
            end
        end
    end

    // ID queue storage: written on issue with the held channel.
    // NOTE: the storage array has no reset; the pointers and occupancy define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[wr_ptr_q] <= held_chan_q;
        end
    end

    // Occupancy after this cycle's push and pop; both together leave it unchanged.
    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + CntW'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - CntW'(1);
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_slot(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_slot(rd_ptr_q);
            end
            occ_q <= occ_d;
        end
    end

    // Per-channel counters: +1 on grant, -1 on completion pop, net 0 if both.
    always_comb begin
        for (int c = 0; c < NumChan; c++) begin
            cnt_d[c] = cnt_q[c];
            if (grant && (grant_idx == ChanIdW'(c))) begin
                cnt_d[c] = cnt_d[c] + CntW'(1);
            end
            if (pop && (head == ChanIdW'(c))) begin
                cnt_d[c] = cnt_d[c] - CntW'(1);
            end
        end
    end

    // Registered status: counters, busy, done pulse, sticky irq/err, idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            chan_busy_o <= '0;
            chan_done_o <= '0;
            irq_o       <= '0;
            err_o       <= 1'b0;
            idle_o      <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            for (int c = 0; c < NumChan; c++) begin
                chan_busy_o[c] <= (cnt_d[c] != '0);
            end
            chan_done_o <= done_d;
            // A completion setting irq wins over a same-cycle clear.
            irq_o <= (irq_o & ~irq_clr_i) | done_d;
            if (err_set) begin
                err_o <= 1'b1;
            end
            idle_o <= (state_d == IDLE) && (occ_d == '0);
        end
    end

endmodule

// File: tb/tb_idma_chan_scheduler.sv
// tb_idma_chan_scheduler
// Directed bench for idma_chan_scheduler. A transaction-level model (issue
// queue, round-robin pointer, sticky flags) predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.

module tb_idma_chan_scheduler;

    localparam int NumChan     = 4;
    localparam int ReqWidth    = 192;
    localparam int MaxInFlight = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NumChan*ReqWidth-1:0] chan_req    = '0;
    logic [NumChan-1:0]          chan_valid  = '0;
    logic [NumChan-1:0]          chan_ready;
    logic [NumChan-1:0]          chan_enable = '0;
    logic [ReqWidth-1:0]         be_req;
    logic                        be_valid;
    logic                        be_ready    = 1'b0;
    logic                        be_complete = 1'b0;
    logic [NumChan-1:0]          chan_done;
    logic [NumChan-1:0]          chan_busy;
    logic [NumChan-1:0]          irq;
    logic [NumChan-1:0]          irq_clr     = '0;
    logic                        idle;
    logic                        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idma_chan_scheduler #(
        .NumChan    (NumChan),
        .ReqWidth   (ReqWidth),
        .MaxInFlight(MaxInFlight)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .chan_req_i   (chan_req),
        .chan_valid_i (chan_valid),
        .chan_ready_o (chan_ready),
        .chan_enable_i(chan_enable),
        .be_req_o     (be_req),
        .be_valid_o   (be_valid),
        .be_ready_i   (be_ready),
        .be_complete_i(be_complete),
        .chan_done_o  (chan_done),
        .chan_busy_o  (chan_busy),
        .irq_o        (irq),
        .irq_clr_i    (irq_clr),
        .idle_o       (idle),
        .err_o        (err)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [ReqWidth-1:0] payload(input int c, input int v);
        return {6{32'(v * 256 + c) ^ 32'h5A5A_0000}};
    endfunction

    function automatic int oh_idx(input logic [NumChan-1:0] v);
        for (int i = 0; i < NumChan; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level model, evaluated at every falling edge.
    // ------------------------------------------------------------------
    bit                  m_offer;
    int                  m_held;
    int                  m_rr;
    logic [ReqWidth-1:0] m_req;
    int                  m_q[$];
    logic [NumChan-1:0]  m_done, m_irq, exp_ready, exp_busy, elig, new_done;
    logic                m_err;
    bit                  m_found;
    int                  m_g, m_n, m_h;

    initial begin
        m_offer = 0; m_held = 0; m_rr = 0; m_req = '0;
        m_done = '0; m_irq = '0; m_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_offer = 0; m_held = 0; m_rr = 0;
                m_q.delete();
                m_done = '0; m_irq = '0; m_err = 1'b0;
            end
            elig      = chan_valid & chan_enable;
            exp_ready = '0;
            m_found   = 0;
            m_g       = 0;
            if (!rst && !m_offer && (m_q.size() < MaxInFlight)) begin
                for (int k = 0; k < NumChan; k++) begin
                    if (!m_found && elig[(m_rr + k) % NumChan]) begin
                        m_found = 1;
                        m_g     = (m_rr + k) % NumChan;
                    end
                end
            end
            if (m_found) exp_ready[m_g] = 1'b1;
            for (int c = 0; c < NumChan; c++) begin
                m_n = (m_offer && m_held == c) ? 1 : 0;
                foreach (m_q[i]) if (m_q[i] == c) m_n++;
                exp_busy[c] = (m_n != 0);
            end

            check("cyc_ready", chan_ready, exp_ready);
            check("cyc_be_valid", be_valid, m_offer);
            if (m_offer) check("cyc_be_req", be_req, m_req);
            check("cyc_done", chan_done, m_done);
            check("cyc_busy", chan_busy, exp_busy);
            check("cyc_irq", irq, m_irq);
            check("cyc_idle", idle, (!m_offer && m_q.size() == 0));
            check("cyc_err", err, m_err);

            if (!rst) begin
                new_done = '0;
                if (be_complete) begin
                    if (m_q.size() > 0) begin
                        m_h = m_q.pop_front();
                        new_done[m_h] = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                m_done = new_done;
                m_irq  = (m_irq & ~irq_clr) | new_done;
                if (m_offer && be_ready) begin
                    m_q.push_back(m_held);
                    m_rr    = (m_held + 1) % NumChan;
                    m_offer = 0;
                end else if (m_found) begin
                    m_offer = 1;
                    m_held  = m_g;
                    m_req   = chan_req[m_g*ReqWidth +: ReqWidth];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        chan_valid  = '0;
        chan_enable = '0;
        be_ready    = 1'b0;
        be_complete = 1'b0;
        irq_clr     = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Raise valid on one channel until it is granted (bounded), then drop it.
    task automatic issue(input int ch);
        bit got;
        got = 0;
        chan_valid[ch] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            #2;
            if (chan_ready[ch]) got = 1;
            step();
        end
        chan_valid[ch] = 1'b0;
        check("issue_grant", got, 1'b1);
    endtask

    int order[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int g;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int c = 0; c < NumChan; c++) chan_req[c*ReqWidth +: ReqWidth] = payload(c, 1);
        step();
        step();
        check("rst_idle", idle, 1'b1);
        check("rst_be_valid", be_valid, 1'b0);
        check("rst_be_req", be_req, '0);
        check("rst_busy", chan_busy, 4'b0000);
        rst = 1'b0;

        // 1. single transfer on ch0
        chan_enable = '1;
        be_ready    = 1'b1;
        chan_valid  = 4'b0001;
        #2 check("t1_ready_c0", chan_ready, 4'b0001);
        step();
        chan_valid = '0;
        #2;
        check("t1_be_valid_c1", be_valid, 1'b1);
        check("t1_be_req_c1", be_req, payload(0, 1));
        check("t1_idle_c1", idle, 1'b0);
        check("t1_busy_c1", chan_busy, 4'b0001);
        step(); step(); step(); step();
        be_complete = 1'b1;
        step();
        be_complete = 1'b0;
        #2;
        check("t1_done_c6", chan_done, 4'b0001);
        check("t1_irq_c6", irq, 4'b0001);
        check("t1_busy_c6", chan_busy, 4'b0000);
        step();
        irq_clr = 4'b0001;
        step();
        irq_clr = '0;
        #2 check("t1_irq_cleared", irq, 4'b0000);

        // 2. all channels valid, backend always ready: round-robin order
        do_reset();
        chan_enable = '1;
        be_ready    = 1'b1;
        chan_valid  = 4'b1111;
        for (int cy = 0; cy < 12; cy++) begin
            be_complete = (cy == 3 || cy == 5 || cy == 7 || cy == 9);
            #2;
            if (chan_ready != '0) order.push_back(oh_idx(chan_ready));
            step();
        end
        chan_valid  = '0;
        be_complete = 1'b0;
        check("t2_grant_count", order.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("t2_grant_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
        end

        // 3. backend stall: offer held stable, disabling the channel keeps it
        do_reset();
        chan_enable = '1;
        be_ready    = 1'b0;
        chan_valid  = 4'b0010;
        #2 check("t3_ready_c0", chan_ready, 4'b0010);
        step();
        chan_valid = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) chan_enable[1] = 1'b0;
            if (i == 5) chan_req[1*ReqWidth +: ReqWidth] = payload(1, 7);
            #2;
            check("t3_stall_valid", be_valid, 1'b1);
            check("t3_stall_req", be_req, payload(1, 1));
            check("t3_stall_ready", chan_ready, 4'b0000);
            step();
        end
        be_ready = 1'b1;
        #2 check("t3_offer_kept", be_valid, 1'b1);
        step();
        #2 check("t3_next_grant", chan_ready, 4'b1000);
        step();
        chan_valid = '0;
        chan_req[1*ReqWidth +: ReqWidth] = payload(1, 1);
        step();

        // 4. in-flight limit
        do_reset();
        chan_enable = '1;
        be_ready    = 1'b1;
        chan_valid  = 4'b0001;
        g = 0;
        for (int cy = 0; cy < 14; cy++) begin
            #2;
            if (chan_ready != '0) g++;
            step();
        end
        check("t4_limit_grants", g, 4);
        be_complete = 1'b1;
        #2;
        if (chan_ready != '0) g++;
        step();
        be_complete = 1'b0;
        for (int cy = 0; cy < 4; cy++) begin
            #2;
            if (chan_ready != '0) g++;
            step();
        end
        check("t4_fifth_grant", g, 5);
        chan_valid = '0;

        // 5. completion routing and irq set-over-clear
        do_reset();
        chan_enable = '1;
        be_ready    = 1'b1;
        issue(2);
        issue(1);
        step();
        be_complete = 1'b1;
        step();
        #2 check("t5_done_ch2", chan_done, 4'b0100);
        step();
        be_complete = 1'b0;
        #2;
        check("t5_done_ch1", chan_done, 4'b0010);
        check("t5_irq_both", irq, 4'b0110);
        irq_clr = 4'b0010;
        step();
        irq_clr = '0;
        #2 check("t5_irq_clr1", irq, 4'b0100);
        issue(2);
        step();
        be_complete = 1'b1;
        irq_clr     = 4'b0100;
        step();
        be_complete = 1'b0;
        irq_clr     = '0;
        #2;
        check("t5_set_wins_done", chan_done, 4'b0100);
        check("t5_set_wins_irq", irq, 4'b0100);
        step();

        // 6. completion on empty queue, then async reset mid-offer
        do_reset();
        chan_enable = '1;
        be_complete = 1'b1;
        step();
        be_complete = 1'b0;
        #2;
        check("t6_err", err, 1'b1);
        check("t6_no_done", chan_done, 4'b0000);
        be_ready = 1'b0;
        step();
        issue(3);
        #2 check("t6_in_offer", be_valid, 1'b1);
        chan_valid[3] = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_arst_be_valid", be_valid, 1'b0);
        check("t6_arst_be_req", be_req, '0);
        check("t6_arst_ready", chan_ready, 4'b0000);
        check("t6_arst_busy", chan_busy, 4'b0000);
        check("t6_arst_idle", idle, 1'b1);
        check("t6_arst_err", err, 1'b0);
        check("t6_arst_irq", irq, 4'b0000);
        step();
        step();
        chan_valid = '0;
        rst        = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
